// File: rtl/rop_color_write_pkg.sv
// Shared ROP colour-write types: RGBA pixel, ROP DCR block, write-mask bit
// positions and the helper that maps a channel write mask onto byte enables.
package rop_color_write_pkg;

    localparam int ROP_WRITEMASK_R = 0;
    localparam int ROP_WRITEMASK_G = 1;
    localparam int ROP_WRITEMASK_B = 2;
    localparam int ROP_WRITEMASK_A = 3;
    localparam int ROP_PIXEL_BYTES = 4;

    // Field order makes the packed value {a,r,g,b}, matching the memory word layout
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgba_t;

    typedef struct packed {
        logic [31:0] cbuf_addr;
        logic [31:0] cbuf_pitch;
        logic [3:0]  cbuf_writemask;
    } rop_dcrs_t;

    // Byte 3 holds alpha, byte 2 red, byte 1 green, byte 0 blue
    function automatic logic [ROP_PIXEL_BYTES-1:0] ropByteen(input logic [3:0] wm);
        return {wm[ROP_WRITEMASK_A], wm[ROP_WRITEMASK_R],
                wm[ROP_WRITEMASK_G], wm[ROP_WRITEMASK_B]};
    endfunction

endpackage

// File: rtl/rop_color_write_wbuf2.sv
// Two-entry FIFO. The head register only changes when a new head is needed,
// so the output holds its last value while empty and stays stable while stalled.
module rop_color_write_wbuf2 #(
    parameter int DATAW = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [DATAW-1:0] i_data,
    output logic [DATAW-1:0] o_data,
    output logic [1:0]       o_count,
    output logic             o_full
);

    logic [DATAW-1:0] r_head;
    logic [DATAW-1:0] r_tail;
    logic [1:0]       r_count;
    logic             r_full;
    logic             w_doPush;
    logic             w_doPop;
    logic [1:0]       w_nextCount;

    assign w_doPush = i_push && !r_full;
    assign w_doPop  = i_pop && (r_count != 2'd0);

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_nextCount = r_count;
        if (w_doPush && !w_doPop) begin
            w_nextCount = r_count + 2'd1;
        end else if (w_doPop && !w_doPush) begin
            w_nextCount = r_count - 2'd1;
        end
    end

    // Count and registered full flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= 2'd0;
            r_full  <= 1'b0;
        end else begin
            r_count <= w_nextCount;
            r_full  <= (w_nextCount == 2'd2);
        end
    end

    // Entry storage: new data lands in the head when the head slot frees up, otherwise in the tail
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_doPush && ((r_count == 2'd0) || ((r_count == 2'd1) && w_doPop))) begin
                r_head <= i_data;
            end else if (w_doPop && (r_count == 2'd2)) begin
                r_head <= r_tail;
            end
            if (w_doPush && (r_count == 2'd1) && !w_doPop) begin
                r_tail <= i_data;
            end
        end
    end

    assign o_data  = r_head;
    assign o_count = r_count;
    assign o_full  = r_full;

endmodule

// File: rtl/rop_color_write.sv
// Final ROP colour stage: packs blended colours, applies the channel write
// mask, drops fully-masked inputs and queues masked write requests to memory.
module rop_color_write
    import rop_color_write_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int TAG_WIDTH = 1,
    parameter int ADDRW     = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  rop_dcrs_t                  i_dcrs,
    input  logic                       i_valid_in,
    input  logic [TAG_WIDTH-1:0]       i_tag_in,
    output logic                       o_ready_in,
    input  logic [NUM_LANES-1:0]       i_mask_in,
    input  logic [NUM_LANES*ADDRW-1:0] i_addr_in,
    input  rgba_t [NUM_LANES-1:0]      i_color_in,
    output logic                       o_mem_req_valid,
    output logic                       o_mem_req_rw,
    output logic [NUM_LANES-1:0]       o_mem_req_mask,
    output logic [4*NUM_LANES-1:0]     o_mem_req_byteen,
    output logic [NUM_LANES*ADDRW-1:0] o_mem_req_addr,
    output logic [32*NUM_LANES-1:0]    o_mem_req_data,
    output logic [TAG_WIDTH-1:0]       o_mem_req_tag,
    input  logic                       i_mem_req_ready,
    output logic [31:0]                o_perf_pixels
);

    typedef struct packed {
        logic [TAG_WIDTH-1:0]       tag;
        logic [NUM_LANES-1:0]       mask;
        logic [4*NUM_LANES-1:0]     byteen;
        logic [NUM_LANES*ADDRW-1:0] addr;
        logic [32*NUM_LANES-1:0]    data;
    } wEntry_t;

    wEntry_t                    w_pushEntry;
    wEntry_t                    w_head;
    logic [4*NUM_LANES-1:0]     w_byteen;
    logic [NUM_LANES-1:0]       w_laneMask;
    logic [32*NUM_LANES-1:0]    w_data;
    logic [1:0]                 w_count;
    logic                       w_full;
    logic                       w_push;
    logic                       w_pop;
    logic [31:0]                w_headPixels;
    logic [31:0]                r_perfPixels;
    logic                       w_unusedDcrs;

    assign w_unusedDcrs = ^{i_dcrs.cbuf_addr, i_dcrs.cbuf_pitch};

    // Per-lane packing and byte enables; uncovered lanes get no byte enables
    always_comb begin
        w_byteen   = '0;
        w_laneMask = '0;
        w_data     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_byteen[i*4 +: 4] = i_mask_in[i] ? ropByteen(i_dcrs.cbuf_writemask) : 4'b0000;
            w_laneMask[i]      = |w_byteen[i*4 +: 4];
            w_data[i*32 +: 32] = i_color_in[i];
        end
    end

    assign w_pushEntry = '{tag: i_tag_in, mask: w_laneMask, byteen: w_byteen,
                           addr: i_addr_in, data: w_data};

    // Inputs with nothing to write are consumed without occupying a buffer slot
    assign o_ready_in = !w_full;
    assign w_push     = i_valid_in && o_ready_in && (|w_laneMask);
    assign w_pop      = o_mem_req_valid && i_mem_req_ready;

    rop_color_write_wbuf2 #(
        .DATAW ($bits(wEntry_t))
    ) u_wbuf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pushEntry),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full)
    );

    assign o_mem_req_valid  = (w_count != 2'd0);
    assign o_mem_req_rw     = 1'b1;
    assign o_mem_req_mask   = w_head.mask;
    assign o_mem_req_byteen = w_head.byteen;
    assign o_mem_req_addr   = w_head.addr;
    assign o_mem_req_data   = w_head.data;
    assign o_mem_req_tag    = w_head.tag;

    // Number of written pixels in the head request
    always_comb begin
        w_headPixels = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_headPixels = w_headPixels + {31'b0, w_head.mask[i]};
        end
    end

    // Pixel counter advances on each completed memory handshake
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_perfPixels <= '0;
        end else if (w_pop) begin
            r_perfPixels <= r_perfPixels + w_headPixels;
        end
    end

    assign o_perf_pixels = r_perfPixels;

endmodule

// File: tb/tb_rop_color_write.sv
// Bench for rop_color_write: directed vectors, a queue-based reference model
// checked every cycle, and hand-computed expectations at key points.
module tb_rop_color_write;
    import rop_color_write_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    rop_dcrs_t     dcrs;
    logic          validIn;
    logic [1:0]    tagIn;
    logic          readyIn;
    logic [3:0]    maskIn;
    logic [127:0]  addrIn;
    rgba_t [3:0]   colorIn;
    logic          memValid;
    logic          memRw;
    logic [3:0]    memMask;
    logic [15:0]   memByteen;
    logic [127:0]  memAddr;
    logic [127:0]  memData;
    logic [1:0]    memTag;
    logic          memReady;
    logic [31:0]   perfPixels;

    int checks = 0;
    int errors = 0;
    bit streaming = 1'b0;
    int streamValid = 0;
    int readyDrops = 0;

    typedef struct {
        logic [1:0]   tag;
        logic [3:0]   mask;
        logic [15:0]  byteen;
        logic [127:0] addr;
        logic [127:0] data;
    } expReq_t;

    expReq_t     modelQ[$];
    logic [31:0] modelPerf = '0;

    always #5 clk = ~clk;

    rop_color_write #(
        .NUM_LANES (4),
        .TAG_WIDTH (2),
        .ADDRW     (32)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_dcrs           (dcrs),
        .i_valid_in       (validIn),
        .i_tag_in         (tagIn),
        .o_ready_in       (readyIn),
        .i_mask_in        (maskIn),
        .i_addr_in        (addrIn),
        .i_color_in       (colorIn),
        .o_mem_req_valid  (memValid),
        .o_mem_req_rw     (memRw),
        .o_mem_req_mask   (memMask),
        .o_mem_req_byteen (memByteen),
        .o_mem_req_addr   (memAddr),
        .o_mem_req_data   (memData),
        .o_mem_req_tag    (memTag),
        .i_mem_req_ready  (memReady),
        .o_perf_pixels    (perfPixels)
    );

    // Single comparison point: counts every check and reports failures
    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Request the current inputs would produce, built per pixel from channel rules
    function automatic expReq_t buildReq();
        expReq_t r;
        logic [3:0] wm;
        wm = dcrs.cbuf_writemask;
        r.tag = tagIn;
        r.addr = addrIn;
        r.byteen = '0;
        r.mask = '0;
        r.data = '0;
        for (int i = 0; i < 4; i++) begin
            if (maskIn[i]) begin
                r.byteen[i*4+3] = wm[3];
                r.byteen[i*4+2] = wm[0];
                r.byteen[i*4+1] = wm[1];
                r.byteen[i*4+0] = wm[2];
            end
            r.mask[i] = (r.byteen[i*4 +: 4] != 4'b0000);
            r.data[i*32 +: 32] = {colorIn[i].a, colorIn[i].r, colorIn[i].g, colorIn[i].b};
        end
        return r;
    endfunction

    task automatic popModel();
        modelPerf <= modelPerf + 32'($countones(modelQ[0].mask));
        void'(modelQ.pop_front());
    endtask

    // Reference model: bounded queue of two, acceptance decided from its own occupancy
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            modelQ.delete();
            modelPerf <= '0;
        end else if (modelQ.size() < 2) begin
            if (modelQ.size() != 0 && memReady) popModel();
            if (validIn && buildReq().mask != 4'b0000) modelQ.push_back(buildReq());
        end else if (memReady) begin
            popModel();
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if ($time > 2) begin
            checkOutput("model_ready", {127'b0, readyIn}, {127'b0, modelQ.size() < 2});
            checkOutput("model_valid", {127'b0, memValid}, {127'b0, modelQ.size() != 0});
            checkOutput("model_rw", {127'b0, memRw}, 128'd1);
            checkOutput("model_perf", {96'b0, perfPixels}, {96'b0, modelPerf});
            if (modelQ.size() != 0) begin
                checkOutput("model_tag", {126'b0, memTag}, {126'b0, modelQ[0].tag});
                checkOutput("model_mask", {124'b0, memMask}, {124'b0, modelQ[0].mask});
                checkOutput("model_byteen", {112'b0, memByteen}, {112'b0, modelQ[0].byteen});
                checkOutput("model_addr", memAddr, modelQ[0].addr);
                checkOutput("model_data", memData, modelQ[0].data);
            end
        end
    end

    // Streaming observation: count requests and any ready deassertion
    always @(negedge clk) begin
        if (streaming) begin
            if (memValid) streamValid++;
            if (!readyIn) readyDrops++;
        end
    end

    function automatic rgba_t [3:0] laneColors(input logic [7:0] seed);
        rgba_t [3:0] c;
        for (int i = 0; i < 4; i++) begin
            c[i].a = seed + 8'(i*4 + 3);
            c[i].r = seed + 8'(i*4);
            c[i].g = seed + 8'(i*4 + 1);
            c[i].b = seed + 8'(i*4 + 2);
        end
        return c;
    endfunction

    task automatic applyStimulus(input logic [1:0] tag, input logic [3:0] mask, input logic [3:0] wm,
                                 input rgba_t [3:0] colors, input logic [31:0] base);
        @(posedge clk);
        #2;
        validIn = 1'b1;
        tagIn = tag;
        maskIn = mask;
        dcrs.cbuf_writemask = wm;
        colorIn = colors;
        addrIn = {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
        validIn = 1'b0;
    endtask

    rgba_t [3:0] cols;

    initial begin
        validIn = 1'b0;
        tagIn = '0;
        maskIn = '0;
        addrIn = '0;
        colorIn = '0;
        dcrs = '0;
        dcrs.cbuf_addr = 32'hDEAD0000;
        dcrs.cbuf_pitch = 32'd256;
        memReady = 1'b1;
        #1 reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_valid", {127'b0, memValid}, 128'd0);
        checkOutput("reset_perf", {96'b0, perfPixels}, 128'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_ready", {127'b0, readyIn}, 128'd1);

        // Single full-mask pixel group
        cols = laneColors(8'h50);
        cols[0] = '{a: 8'h44, r: 8'h11, g: 8'h22, b: 8'h33};
        applyStimulus(2'd0, 4'hF, 4'hF, cols, 32'h1000);
        idle();
        @(negedge clk);
        checkOutput("single_valid", {127'b0, memValid}, 128'd1);
        checkOutput("single_data0", {96'b0, memData[31:0]}, 128'h44112233);
        checkOutput("single_byteen0", {124'b0, memByteen[3:0]}, 128'hF);
        checkOutput("single_mask", {124'b0, memMask}, 128'hF);
        @(negedge clk);
        checkOutput("single_perf", {96'b0, perfPixels}, 128'd4);

        // Red+blue write mask on two covered lanes
        applyStimulus(2'd1, 4'b0011, 4'b0101, laneColors(8'h60), 32'h2000);
        idle();
        @(negedge clk);
        checkOutput("wm_byteen", {112'b0, memByteen}, 128'h0055);
        checkOutput("wm_mask", {124'b0, memMask}, 128'h3);
        @(negedge clk);
        checkOutput("wm_perf", {96'b0, perfPixels}, 128'd6);

        // Dropped inputs: no coverage, then no write mask
        applyStimulus(2'd2, 4'b0000, 4'hF, laneColors(8'h70), 32'h2800);
        applyStimulus(2'd3, 4'hF, 4'b0000, laneColors(8'h78), 32'h2900);
        idle();
        @(negedge clk);
        checkOutput("drop_ready", {127'b0, readyIn}, 128'd1);
        checkOutput("drop_valid", {127'b0, memValid}, 128'd0);
        checkOutput("drop_perf", {96'b0, perfPixels}, 128'd6);

        // Back-pressure: third input held while full, head stable
        memReady = 1'b0;
        applyStimulus(2'd0, 4'hF, 4'hF, laneColors(8'h80), 32'h3000);
        applyStimulus(2'd1, 4'hF, 4'hF, laneColors(8'h90), 32'h3100);
        applyStimulus(2'd2, 4'hF, 4'hF, laneColors(8'hA0), 32'h3200);
        @(negedge clk);
        checkOutput("bp_ready_low", {127'b0, readyIn}, 128'd0);
        checkOutput("bp_head_tag", {126'b0, memTag}, 128'd0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("bp_stall_tag", {126'b0, memTag}, 128'd0);
            checkOutput("bp_stall_addr", {96'b0, memAddr[31:0]}, 128'h3000);
        end
        @(posedge clk);
        #2 memReady = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_tag0", {126'b0, memTag}, 128'd0);
        @(negedge clk);
        checkOutput("bp_tag1", {126'b0, memTag}, 128'd1);
        checkOutput("bp_ready_back", {127'b0, readyIn}, 128'd1);
        @(posedge clk);
        #2 validIn = 1'b0;
        @(negedge clk);
        checkOutput("bp_tag2", {126'b0, memTag}, 128'd2);
        checkOutput("bp_addr2", {96'b0, memAddr[31:0]}, 128'h3200);
        @(negedge clk);
        checkOutput("bp_drained", {127'b0, memValid}, 128'd0);
        checkOutput("bp_perf", {96'b0, perfPixels}, 128'd18);

        // Streaming sixteen full-mask inputs
        streaming = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2'(i), 4'hF, 4'hF, laneColors(8'(i*8)), 32'h4000 + 32'(i*16));
        end
        idle();
        repeat (2) @(negedge clk);
        #1 streaming = 1'b0;
        checkOutput("stream_requests", 128'(streamValid), 128'd16);
        checkOutput("stream_ready_drops", 128'(readyDrops), 128'd0);
        checkOutput("stream_perf", {96'b0, perfPixels}, 128'd82);

        // Asynchronous reset with the buffer full
        memReady = 1'b0;
        applyStimulus(2'd1, 4'hF, 4'hF, laneColors(8'hC0), 32'h5000);
        applyStimulus(2'd2, 4'hF, 4'hF, laneColors(8'hD0), 32'h5100);
        idle();
        @(negedge clk);
        checkOutput("rst_full_ready", {127'b0, readyIn}, 128'd0);
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_async_valid", {127'b0, memValid}, 128'd0);
        checkOutput("rst_async_perf", {96'b0, perfPixels}, 128'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        memReady = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_no_stale", {127'b0, memValid}, 128'd0);
            checkOutput("rst_ready", {127'b0, readyIn}, 128'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
